snail_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter, the sending end of the snail "101" detector link.

---
 rtl/snail_pattern_tx.sv | 204 ++++++++++++++++++++
 tb/tb_snail_pattern_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/snail_pattern_tx.sv
// snail_pattern_tx -- serial bit-pattern transmitter for the snail "101" link.
//
// Captures a WIDTH-bit word when start is seen in IDLE and shifts it out on D,
// one bit per clock, with no gaps. While the frame is on the line it counts
// overlapping "101" occurrences in the emitted stream (hits). The count can be
// compared against the far-end Mealy 101 detector.
//
// Parameters:
//   WIDTH      frame length in bits (>= 3)
//   MSB_FIRST  1: data[WIDTH-1] goes out first; 0: data[0] goes out first
//   HW         width of hits, $clog2(WIDTH)
//
// Ports:
//   clk    in   1      rising-edge clock
//   _rst   in   1      asynchronous reset, active low
//   start  in   1      frame request, only looked at in IDLE
//   data   in   WIDTH  frame word, captured on the accepted start edge
//   D      out  1      registered serial output, idles at 0
//   busy   out  1      registered, high while bits are on the line
//   done   out  1      registered, one-cycle pulse after the last bit
//   hits   out  HW     registered count of overlapping "101" in the frame
//   rep    in   1      only with SNAIL_TX_REPEAT_EN: resend the word back to back
//
// Optional feature macro: SNAIL_TX_REPEAT_EN (adds rep and a copy of the word).

module snail_pattern_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int HW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             _rst,
`ifdef SNAIL_TX_REPEAT_EN
  input  logic             rep,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             D,
  output logic             busy,
  output logic             done,
  output logic [HW-1:0]    hits
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             d_reg, d_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [HW-1:0]    hits_reg, hits_next;
  logic [1:0]       hist_reg, hist_next;

  // Repeat request and the word to resend; constant-false when the feature is off.
  logic             rep_now;
  logic [WIDTH-1:0] reload_word;

`ifdef SNAIL_TX_REPEAT_EN
  logic [WIDTH-1:0] copy_reg, copy_next;

  assign rep_now     = rep;
  assign reload_word = copy_reg;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) copy_reg <= '0;
    else       copy_reg <= copy_next;
  end
`else
  assign rep_now     = 1'b0;
  assign reload_word = '0;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // shreg keeps the whole captured word; the bit after the one on D sits
  // next to the end that was emitted first, and the word shifts toward it.
  function automatic logic following_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-2] : w[1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      d_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      hits_reg  <= '0;
      hist_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      hits_reg  <= hits_next;
      hist_reg  <= hist_next;
    end
  end

  logic load_d;   // D is (re)loaded on this edge, so hist shifts
  logic count_d;  // the loaded bit may extend a "101" within the frame

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    d_next     = d_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    hits_next  = hits_reg;
    hist_next  = hist_reg;
    load_d     = 1'b0;
    count_d    = 1'b0;
`ifdef SNAIL_TX_REPEAT_EN
    copy_next  = copy_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          shreg_next = data;
          d_next     = first_bit(data);
          cnt_next   = CW'(WIDTH - 1);
          hits_next  = '0;
          busy_next  = 1'b1;
          state_next = SHIFT;
          load_d     = 1'b1;
`ifdef SNAIL_TX_REPEAT_EN
          copy_next  = data;
`endif
        end
      end

      SHIFT: begin
        done_next = 1'b0;
        if (cnt_reg != '0) begin
          d_next     = following_bit(shreg_reg);
          shreg_next = advance(shreg_reg);
          cnt_next   = cnt_reg - CW'(1);
          load_d     = 1'b1;
          count_d    = 1'b1;
        end else if (rep_now) begin
          // Back-to-back resend: first bit of the next frame replaces the
          // trailing 0, and the new count starts with the boundary match.
          shreg_next = reload_word;
          d_next     = first_bit(reload_word);
          cnt_next   = CW'(WIDTH - 1);
          done_next  = 1'b1;
          load_d     = 1'b1;
          hits_next  = HW'({hist_reg, d_next} == 3'b101);
        end else begin
          d_next     = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = FIN;
          load_d     = 1'b1;
        end
      end

      FIN: begin
        done_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        d_next     = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        hits_next  = '0;
        load_d     = 1'b1;
      end
    endcase

    if (load_d) begin
      hist_next = {hist_reg[0], d_next};
    end
    if (count_d && ({hist_reg, d_next} == 3'b101) && (hits_reg != {HW{1'b1}})) begin
      hits_next = hits_reg + HW'(1);
    end
  end

  assign D    = d_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign hits = hits_reg;

endmodule

// File: tb/tb_snail_pattern_tx.sv
// Testbench for snail_pattern_tx (WIDTH=8, MSB_FIRST=1, default build).
// Table of known frames, reset/restart/abort sequences, then random frames
// checked against a bit-list reference model.

module tb_snail_pattern_tx;

  localparam int WIDTH     = 8;
  localparam bit MSB_FIRST = 1'b1;
  localparam int HW        = $clog2(WIDTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    data;
  logic          d_out;
  logic          busy;
  logic          done;
  logic [HW-1:0] hits;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  snail_pattern_tx #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
    .clk   (clk),
    ._rst  (rst_n),
`ifdef SNAIL_TX_REPEAT_EN
    .rep   (1'b0),
`endif
    .start (start),
    .data  (data),
    .D     (d_out),
    .busy  (busy),
    .done  (done),
    .hits  (hits)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] stream;  // line order: stream[7] is the first bit on D
    int         hits;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: bit k of the frame in transmit order.
  function automatic logic [7:0] model_stream(input logic [7:0] d);
    logic [7:0] s;
    for (int k = 0; k < 8; k++) s[7-k] = MSB_FIRST ? d[7-k] : d[k];
    return s;
  endfunction

  // Reference: overlapping "101" windows lying inside the frame.
  function automatic int model_hits(input logic [7:0] s);
    int n = 0;
    for (int k = 0; k + 2 < 8; k++)
      if (s[7-k] == 1'b1 && s[6-k] == 1'b0 && s[5-k] == 1'b1) n++;
    return n;
  endfunction

  // Sends one frame and checks every cycle through the return to IDLE.
  // restart_at >= 0 re-asserts start during bit restart_at and in FIN.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] s, input int eh,
                           input int restart_at);
    int dones = 0;
    start = 1'b1;
    data  = d;
    step();
    start = 1'b0;
    data  = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bit%0d_D", k), 32'(d_out), 32'(s[7-k]));
      check($sformatf("bit%0d_busy", k), 32'(busy), 32'd1);
      if (done) dones++;
      start = (k == restart_at);
      step();
    end
    start = 1'b0;
    check("end_D", 32'(d_out), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_hits", 32'(hits), 32'(eh));
    if (done) dones++;
    if (restart_at >= 0) start = 1'b1;
    step();
    start = 1'b0;
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_hits", 32'(hits), 32'(eh));
    if (done) dones++;
    step();
    check("no_extra_frame", 32'(busy), 32'd0);
    check("done_pulses", 32'(dones), 32'd1);
    $display("[TB] frame data=%02h hits=%0d expected=%0d", d, hits, eh);
  endtask

  initial begin
    vecs[0] = '{8'hAD, 8'b10101101, 3};
    vecs[1] = '{8'hFF, 8'b11111111, 0};
    vecs[2] = '{8'h55, 8'b01010101, 3};
    vecs[3] = '{8'h00, 8'b00000000, 0};
    vecs[4] = '{8'h5A, 8'b01011010, 2};
    vecs[5] = '{8'hAA, 8'b10101010, 3};

    // Reset held with start high and clock running.
    rst_n = 1'b0;
    start = 1'b1;
    data  = 8'hAD;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_D", 32'(d_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_hits", 32'(hits), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Known frames.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].data, vecs[i].stream, vecs[i].hits, -1);
    end

    // start re-asserted at bit 3 and in FIN: one frame, one done.
    run_frame(8'hAD, 8'b10101101, 3, 3);

    // Reset pulsed at bit 4 aborts at once, then a full frame follows.
    start = 1'b1;
    data  = 8'hAD;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("abort_bit4_D", 32'(d_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_D", 32'(d_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hits", 32'(hits), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    step();
    check("abort_idle_done", 32'(done), 32'd0);
    run_frame(8'h55, 8'b01010101, 3, -1);

    // Random frames against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      logic [7:0] s;
      int gap;
      d   = 8'($urandom);
      s   = model_stream(d);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step();
        check("gap_busy", 32'(busy), 32'd0);
      end
      run_frame(d, s, model_hits(s), (i % 5 == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
